// File: rtl/reset_seq.sv
// Reset sequencer: conditions the board reset sources, holds a set of
// active-low resets asserted for a programmable time after the last trigger,
// then releases them one at a time in index order with a fixed gap.
// Also tracks the source of the most recent reset in a small cause register.
module reset_seq #(
    parameter int HOLD_CYCLES     = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int NUM_OUT         = 4,
    parameter int STAGE_GAP       = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fpga_but1,
    input  logic               fpga_start,
    input  logic               soft_req,
    output logic [NUM_OUT-1:0] reset_n,
    output logic               busy,
    output logic [1:0]         cause
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    // Terminal counts; every counter stops here instead of wrapping.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RESET  = 2'd0,
        CAUSE_START  = 2'd1,
        CAUSE_BUTTON = 2'd2,
        CAUSE_SOFT   = 2'd3
    } cause_t;

    logic               start_meta;
    logic               start_sync;
    logic               but_meta;
    logic               but_sync;
    logic               but_stable;
    logic [DEB_W-1:0]   deb_cnt;
    logic               trig;
    cause_t             trig_cause;
    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   stage_cnt;
    logic [NUM_OUT-1:0] next_mask;

    // Two-flop synchronisers for the asynchronous board inputs; idle level is high.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge value, forming a real 2-stage chain.
        if (reset) begin
            start_meta <= 1'b1;
            start_sync <= 1'b1;
            but_meta   <= 1'b1;
            but_sync   <= 1'b1;
        end else begin
            start_meta <= fpga_start;
            start_sync <= start_meta;
            but_meta   <= fpga_but1;
            but_sync   <= but_meta;
        end
    end

    // Button debounce: accept a new level only after it has differed from the stable one for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            but_stable <= 1'b1;
            deb_cnt    <= '0;
        end else if (but_sync == but_stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            but_stable <= but_sync;
            deb_cnt    <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign trig = reset | ~start_sync | ~but_stable | soft_req;

    // Highest-priority active trigger source, used to load the cause register.
    always_comb begin
        // NOTE: assign a default before the priority chain so every path drives trig_cause and no latch is inferred.
        trig_cause = CAUSE_SOFT;
        if (reset) begin
            trig_cause = CAUSE_RESET;
        end else if (!start_sync) begin
            trig_cause = CAUSE_START;
        end else if (!but_stable) begin
            trig_cause = CAUSE_BUTTON;
        end
    end

    // Outputs released so far plus the next one; the outputs form a thermometer code from bit 0 up.
    assign next_mask = NUM_OUT'({reset_n, 1'b1});

    // Sequencer: hold all resets while triggered, count the hold time, then release stage by stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ASSERT;
            reset_n   <= '0;
            busy      <= 1'b1;
            hold_cnt  <= '0;
            stage_cnt <= '0;
            cause     <= CAUSE_RESET;
        end else if (trig) begin
            // Any trigger, in any state, pulls every output low on this edge and restarts the hold.
            state     <= ST_ASSERT;
            reset_n   <= '0;
            busy      <= 1'b1;
            hold_cnt  <= '0;
            stage_cnt <= '0;
            cause     <= trig_cause;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        reset_n   <= next_mask;
                        stage_cnt <= '0;
                        // With a single output the first release is also the last.
                        if (&next_mask) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (stage_cnt == GAP_LAST) begin
                        reset_n   <= next_mask;
                        stage_cnt <= '0;
                        if (&next_mask) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                        end
                    end else begin
                        stage_cnt <= stage_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    reset_n <= '1;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= ST_ASSERT;
                    reset_n <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Testbench for reset_seq: directed scenarios with hand-computed edge numbers,
// then randomized trigger activity, all compared every edge against a
// behavioural model based on "edges elapsed since the last trigger".
module tb_reset_seq;

    localparam int H  = 20;
    localparam int DB = 4;
    localparam int G  = 3;
    localparam int NO = 3;

    logic          clk;
    logic          reset;
    logic          fpga_but1;
    logic          fpga_start;
    logic          soft_req;
    logic [NO-1:0] reset_n;
    logic          busy;
    logic [1:0]    cause;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    reset_seq #(
        .HOLD_CYCLES    (H),
        .DEBOUNCE_CYCLES(DB),
        .NUM_OUT        (NO),
        .STAGE_GAP      (G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fpga_but1 (fpga_but1),
        .fpga_start(fpga_start),
        .soft_req  (soft_req),
        .reset_n   (reset_n),
        .busy      (busy),
        .cause     (cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Short rings of sampled inputs (indexed by edge
    // number mod 16) give the synchronised and debounced levels; the
    // outputs then follow from the age of the most recent trigger:
    // bit k is high once age >= H + k*G, busy until the last bit is up.
    // ------------------------------------------------------------------
    bit         r_h  [16];
    bit         s_h  [16];
    bit         b_h  [16];
    bit         ss_h [16];
    bit         bs_h [16];
    bit         st_h [16];
    int         last_trig;
    logic [1:0] m_cause;

    initial begin : model
        int            n0, n1, age;
        bit            v, flip, trig;
        logic [NO-1:0] exp_rn;
        logic          exp_busy;
        for (int i = 0; i < 16; i++) begin
            r_h[i] = 1'b1; s_h[i] = 1'b1; b_h[i] = 1'b1;
            ss_h[i] = 1'b1; bs_h[i] = 1'b1; st_h[i] = 1'b1;
        end
        last_trig = 0;
        m_cause   = 2'd0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            n0  = cyc & 15;
            n1  = (cyc - 1) & 15;
            r_h[n0] = reset;
            s_h[n0] = fpga_start;
            b_h[n0] = fpga_but1;
            // Synchronised level after this edge: the input sampled one edge earlier.
            ss_h[n0] = (r_h[n0] || r_h[n1]) ? 1'b1 : s_h[n1];
            bs_h[n0] = (r_h[n0] || r_h[n1]) ? 1'b1 : b_h[n1];
            trig = r_h[n0] || !ss_h[n1] || !st_h[n1] || soft_req;
            // Debounced level flips once the synced level has shown the opposite value for DB edges without reset.
            if (r_h[n0]) begin
                st_h[n0] = 1'b1;
            end else begin
                v    = !st_h[n1];
                flip = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (r_h[(cyc - j) & 15] || bs_h[(cyc - j - 1) & 15] != v) flip = 1'b0;
                st_h[n0] = flip ? v : st_h[n1];
            end
            if (trig) begin
                last_trig = cyc;
                if (r_h[n0])        m_cause = 2'd0;
                else if (!ss_h[n1]) m_cause = 2'd1;
                else if (!st_h[n1]) m_cause = 2'd2;
                else                m_cause = 2'd3;
            end
            age = cyc - last_trig;
            for (int k = 0; k < NO; k++) exp_rn[k] = (age >= H + k * G);
            exp_busy = (age < H + (NO - 1) * G);
            #1;
            check("edge_model {reset_n,busy,cause}", {reset_n, busy, cause}, {exp_rn, exp_busy, m_cause});
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic at_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neg_after(input int e);
        @(negedge clk);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic wait_rise(input int idx, input int want, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (reset_n[idx] === 1'b1) seen = 1'b1;
        end
        check(name, seen ? cyc : 32'hFFFF_FFFF, want);
    endtask

    initial begin : stim
        int e0, f, g, b, p, s;
        reset      = 1'b1;
        fpga_but1  = 1'b1;
        fpga_start = 1'b1;
        soft_req   = 1'b0;

        // Power-up: reset sampled high on edges 1 and 2.
        @(posedge clk); #1;
        check("por_reset_n", reset_n, 3'b000);
        check("por_busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        e0 = cyc;
        wait_rise(0, e0 + 20, "por_bit0_edge");
        wait_rise(1, e0 + 23, "por_bit1_edge");
        wait_rise(2, e0 + 26, "por_bit2_edge");
        check("por_busy_low", busy, 1'b0);
        check("por_cause", cause, 2'd0);

        // fpga_start low for 50 cycles while running.
        neg_after(cyc + 5);
        fpga_start = 1'b0;
        f = cyc + 1;
        at_edge(f + 1);
        check("start_before_sync", reset_n, 3'b111);
        at_edge(f + 2);
        check("start_reset_n_low", reset_n, 3'b000);
        check("start_cause", cause, 2'd1);
        neg_after(f + 49);
        fpga_start = 1'b1;
        wait_rise(0, f + 71, "start_bit0_edge");
        check("start_cause_kept", cause, 2'd1);
        wait_rise(2, f + 77, "start_bit2_edge");

        // Button glitch of 3 cycles is rejected.
        neg_after(cyc + 3);
        fpga_but1 = 1'b0;
        g = cyc + 1;
        neg_after(g + 2);
        fpga_but1 = 1'b1;
        at_edge(g + 15);
        check("glitch_reset_n", reset_n, 3'b111);
        check("glitch_cause", cause, 2'd1);

        // Button held low for 10 cycles.
        neg_after(cyc + 2);
        fpga_but1 = 1'b0;
        b = cyc + 1;
        at_edge(b + 5);
        check("button_before_debounce", reset_n, 3'b111);
        at_edge(b + 6);
        check("button_reset_n_low", reset_n, 3'b000);
        check("button_cause", cause, 2'd2);
        neg_after(b + 9);
        fpga_but1 = 1'b1;
        wait_rise(0, b + 35, "button_bit0_edge");
        wait_rise(2, b + 41, "button_bit2_edge");

        // soft_req pulse, then a second one 10 cycles later restarts the hold.
        neg_after(cyc + 2);
        soft_req = 1'b1;
        p = cyc + 1;
        @(negedge clk);
        soft_req = 1'b0;
        check("soft_reset_n_low", reset_n, 3'b000);
        check("soft_cause", cause, 2'd3);
        neg_after(p + 9);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        wait_rise(0, p + 30, "soft_restart_bit0_edge");

        // fpga_start low and soft_req together during RELEASE.
        @(negedge clk);
        fpga_start = 1'b0;
        soft_req   = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        soft_req = 1'b0;
        check("simul_reset_n_low", reset_n, 3'b000);
        check("simul_cause_soft", cause, 2'd3);
        @(negedge clk);
        check("simul_cause_soft_hold", cause, 2'd3);
        @(negedge clk);
        check("simul_cause_start", cause, 2'd1);
        neg_after(s + 5);
        fpga_start = 1'b1;
        wait_rise(0, s + 27, "simul_bit0_edge");

        // soft_req sampled on the edge that would release bit 1.
        neg_after(s + 29);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        check("stage_edge_soft_reset_n", reset_n, 3'b000);
        check("stage_edge_soft_cause", cause, 2'd3);

        // Randomized trigger activity, checked by the per-edge model.
        for (int ep = 0; ep < 150; ep++) begin
            int kind;
            kind = $urandom_range(0, 9);
            @(negedge clk);
            case (kind)
                0, 1, 2, 3: repeat ($urandom_range(1, 60)) @(negedge clk);
                4, 5: begin
                    fpga_but1 = 1'b0;
                    repeat ($urandom_range(1, 9)) @(negedge clk);
                    fpga_but1 = 1'b1;
                end
                6: begin
                    fpga_start = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    fpga_start = 1'b1;
                end
                7: begin
                    soft_req = 1'b1;
                    @(negedge clk);
                    soft_req = 1'b0;
                end
                8: begin
                    reset = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    reset = 1'b0;
                end
                default: begin
                    repeat (12) begin
                        fpga_but1 = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    fpga_but1 = 1'b1;
                end
            endcase
        end
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised power-on and button reset sequencer. It sits between the board inputs (FPGA start flag, push button, PLL/system reset) and the core. It holds a set of active-low reset outputs asserted for a programmable time. It then releases them one after another in index order, so that clock-domain and peripheral blocks come out of reset in a defined sequence. It adds button debouncing, a software reset request and a latched reset-cause register.

## Interface
- HOLD_CYCLES, 5_000_000, cycles all outputs stay asserted after the last trigger clears (500 ms at 10 MHz); ≥1
- DEBOUNCE_CYCLES, 100_000, cycles the synchronised button must be stable before its level is accepted (10 ms); ≥1
- NUM_OUT, 4, number of reset outputs; ≥1
- STAGE_GAP, 1000, cycles between successive output releases; ≥1

- clk  in  1  system clock, 10 MHz nominal
- reset  in  1  synchronous, active-high reset, e.g. PLL not locked
- fpga_but1  in  1  asynchronous, active-low push button
- fpga_start  in  1  asynchronous, active-low; low while FPGA configuration is not finished
- soft_req  in  1  synchronous single-cycle pulse, active-high, software reset request
- reset_n  out  NUM_OUT  active-low resets; bit 0 is released first
- busy  out  1  high while any reset_n bit is low
- cause  out  2  latched last reset cause: 0 reset, 1 fpga_start, 2 button, 3 soft_req

## Operation
- **Input conditioning**
  - fpga_but1 and fpga_start each pass through a 2-FF synchroniser.
  - Button debounce: a counter increments while the synchronised level differs from the stable level. It clears when the two levels are equal. When the count reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronised level.
  - fpga_start is not debounced.
- **Trigger**: trig = reset | !start_sync | !but_stable | soft_req.
- **State machine**: ASSERT, RELEASE, RUN.
  - ASSERT: all reset_n bits low. hold_cnt clears on any cycle with trig; otherwise it increments. On a cycle with hold_cnt==HOLD_CYCLES-1 and no trig: go to RELEASE, set reset_n[0]=1, clear stage_cnt and stage index.
  - RELEASE: stage_cnt counts to STAGE_GAP-1, then the next bit is released and stage_cnt clears. After bit NUM_OUT-1 is released: go to RUN. If NUM_OUT==1, ASSERT goes directly to RUN.
  - RUN: all outputs high, busy low.
  - trig in RELEASE or RUN: go to ASSERT. All bits go low at the same edge and hold_cnt clears.
- A held button or a held-low fpga_start keeps the block in ASSERT indefinitely. The hold time counts from release of the trigger.
- **Cause**
  - Loaded on every cycle where trig is active, using the highest-priority active source: reset > fpga_start > button > soft_req.
  - Retained otherwise.
- **Counter widths**: $clog2 of the respective parameter, minimum 1. Counters never wrap; they saturate at their terminal value.

## Timing
- **Reset values** (edge with reset=1): state ASSERT, reset_n all 0, busy 1, cause 0, hold_cnt 0, synchronisers 1, stable button level 1, debounce counter 0.
- **Trigger to outputs low**:
  - reset: the same edge.
  - soft_req: the edge sampling the pulse.
  - fpga_start low: 3 edges after the first edge that samples it low.
  - button: 3 + DEBOUNCE_CYCLES edges after the first sampling edge.
- **Release timing**: reset_n[0] rises on the HOLD_CYCLES-th edge after the last cycle with trig. reset_n[k] rises k·STAGE_GAP edges after reset_n[0].
- **busy** is registered and falls on the same edge that reset_n[NUM_OUT-1] rises.
- **Glitch rejection**: a button glitch shorter than DEBOUNCE_CYCLES cycles produces no trigger.
- **Simultaneous events**: soft_req on the same edge as a stage release re-enters ASSERT, and no bit is released.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=20, DEBOUNCE_CYCLES=4, STAGE_GAP=3, NUM_OUT=3.

- **Power-up**: reset high for 2 cycles, then low, inputs idle high.
  - reset_n=000 and busy=1 during reset.
  - Bit 0 rises 20 edges after reset falls, bit 1 at +23, bit 2 at +26.
  - busy falls with bit 2; cause=0.
- **fpga_start low for 50 cycles in RUN**:
  - reset_n=000 three edges after it goes low.
  - Bit 0 releases 20 edges after the synchronised level returns high; cause=1.
- **Button glitch low for 3 cycles**: no change to reset_n.
- **Button low for 10 cycles**:
  - reset_n drops at 3+4 edges; cause=2.
  - Release 20 edges after the debounced level returns high.
- **soft_req pulse in RUN**:
  - reset_n=000 at the sampling edge; cause=3.
  - A second soft_req 10 cycles later restarts the hold, so bit 0 rises 20 edges after the second pulse.
- **Simultaneous triggers**: fpga_start low and soft_req on the same cycle during RELEASE (after bit 0 is released) → all bits low; cause=1 once the synchroniser delivers fpga_start, following cause=3 from soft_req at the sampling edge.
